// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    StSync,
    StLenLo,
    StLenHi,
    StData,
    StCsum,
    StRun,
    StErr
  } boot_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // States in which the inter-byte timeout is armed.
  function automatic logic in_frame(input boot_state_t s);
    return (s == StLenLo) || (s == StLenHi) || (s == StData) || (s == StCsum);
  endfunction

endpackage

// File: rtl/imem_boot_loader.sv
// Receives a framed, checksummed image over UART, writes it into instruction memory
// and holds the core stalled until the image is verified.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned TIMEOUT   = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  logic                 boot_req,
  input  logic [BUS_WIDTH-1:0] fetch_addr,
  output logic [BUS_WIDTH-1:0] imem_addr,
  output logic                 mem_we,
  output logic [BUS_WIDTH-1:0] mem_waddr,
  output logic [7:0]           mem_wdata,
  output logic                 core_stall,
  output logic                 load_done,
  output logic                 err
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  boot_state_t          state_q, state_d;
  logic [15:0]          len_q, len_d;
  logic [15:0]          count_q, count_d;
  logic [7:0]           sum_q, sum_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 we_q, we_d;
  logic [BUS_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [15:0]          len_full;

  assign len_full = {rx_data, len_q[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StSync;
      len_q   <= '0;
      count_q <= '0;
      sum_q   <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    sum_d   = sum_q;
    tmo_d   = '0;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      StSync: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = StLenLo;
          count_d = '0;
          sum_d   = '0;
        end
      end
      StLenLo: begin
        if (rx_valid) begin
          len_d[7:0] = rx_data;
          state_d    = StLenHi;
        end
      end
      StLenHi: begin
        if (rx_valid) begin
          len_d = len_full;
          if (32'(len_full) > DEPTH) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else if (len_full == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (rx_valid) begin
          we_d    = 1'b1;
          waddr_d = BUS_WIDTH'(count_q);
          wdata_d = rx_data;
          count_d = count_q + 16'd1;
          sum_d   = sum_q + rx_data;
          if (count_q + 16'd1 == len_q) state_d = StCsum;
        end
      end
      StCsum: begin
        if (rx_valid) begin
          if (rx_data == sum_q) begin
            state_d = StRun;
            done_d  = 1'b1;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
      end
      StRun: begin
        // boot_req has priority; any byte strobed alongside it is dropped
        if (boot_req) begin
          state_d = StSync;
          count_d = '0;
          sum_d   = '0;
        end
      end
      StErr: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = StLenLo;
          err_d   = 1'b0;
          count_d = '0;
          sum_d   = '0;
        end
      end
      default: state_d = StSync;
    endcase

    // Inter-byte watchdog; writes already issued stay in memory
    if (in_frame(state_q) && !rx_valid) begin
      if (tmo_q == TMO_LAST) begin
        state_d = StErr;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  assign core_stall = (state_q != StRun);
  assign mem_we     = we_q;
  assign mem_waddr  = waddr_q;
  assign mem_wdata  = wdata_q;
  assign load_done  = done_q;
  assign err        = err_q;
  assign imem_addr  = core_stall ? waddr_q : fetch_addr;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench: frame stimulus pushes expected memory writes, a monitor pops them.
module tb_imem_boot_loader;
  localparam int unsigned BW      = 32;
  localparam int unsigned DEPTH   = 4096;
  localparam int unsigned TIMEOUT = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          boot_req = 1'b0;
  logic [BW-1:0] fetch_addr = '0;
  logic [BW-1:0] imem_addr;
  logic          mem_we;
  logic [BW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic          core_stall;
  logic          load_done;
  logic          err;

  imem_boot_loader #(
    .BUS_WIDTH(BW),
    .DEPTH    (DEPTH),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .boot_req  (boot_req),
    .fetch_addr(fetch_addr),
    .imem_addr (imem_addr),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .core_stall(core_stall),
    .load_done (load_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int seen_done = 0;
  int exp_done  = 0;
  logic [BW+7:0] exp_q[$];
  logic [BW-1:0] last_waddr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every write must match the next expected (addr, data) from the model.
  always @(posedge clk) begin
    #1;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {mem_waddr, mem_wdata}, 64'hDEAD);
      end else begin
        logic [BW+7:0] e;
        e = exp_q.pop_front();
        check("write_addr", mem_waddr, e[BW+7:8]);
        check("write_data", mem_wdata, e[7:0]);
        check("write_while_stalled", core_stall, 1);
      end
    end
    if (load_done === 1'b1) seen_done++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  function automatic int rgap();
    return $urandom_range(0, 2);
  endfunction

  task automatic strobe(input logic [7:0] b, input bit we_exp, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    check("we_latency", mem_we, we_exp);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_boot_req();
    @(negedge clk);
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
    check("stall_after_boot_req", core_stall, 1);
  endtask

  // Sends a complete frame; csum_xor != 0 corrupts the checksum byte.
  task automatic send_frame(input logic [7:0] pl[$], input logic [7:0] csum_xor);
    logic [7:0] s;
    int n;
    s = 8'h00;
    n = pl.size();
    strobe(8'hA5, 0, rgap());
    strobe(n[7:0], 0, rgap());
    strobe(n[15:8], 0, rgap());
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({BW'(i), pl[i]});
      last_waddr = BW'(i);
      s = s + pl[i];
      strobe(pl[i], 1, rgap());
    end
    strobe(s ^ csum_xor, 0, rgap());
    if (csum_xor == 8'h00) exp_done++;
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_loaded(input string tag);
    check({tag, "_done"}, seen_done, exp_done);
    check({tag, "_stall"}, core_stall, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_pending"}, exp_q.size(), 0);
    fetch_addr = BW'($urandom);
    #1;
    check({tag, "_imem_addr"}, imem_addr, fetch_addr);
  endtask

  task automatic expect_error(input string tag);
    check({tag, "_err"}, err, 1);
    check({tag, "_stall"}, core_stall, 1);
    check({tag, "_done"}, seen_done, exp_done);
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] g;
    int n;
    bit bad;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_stall", core_stall, 1);
    check("rst_we", mem_we, 0);
    check("rst_waddr", mem_waddr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_done", load_done, 0);
    check("rst_err", err, 0);
    check("rst_imem_addr", imem_addr, 0);

    // 1: basic load with leading garbage in SYNC
    strobe(8'h3C, 0, 1);
    pl = {8'h13, 8'h00, 8'h00, 8'h00};
    send_frame(pl, 8'h00);
    expect_loaded("t1");

    // 2: bad checksum, then recovery from ERR
    pulse_boot_req();
    pl = {8'h11, 8'h22};
    send_frame(pl, 8'h07);
    expect_error("t2");
    strobe(8'h5B, 0, 1);
    check("t2_err_sticky", err, 1);
    pl = {8'hDE, 8'hAD, 8'hBE};
    send_frame(pl, 8'h00);
    expect_loaded("t2b");

    // 3: oversize lengths, and the empty-image boundary
    pulse_boot_req();
    strobe(8'hA5, 0, 0);
    strobe(8'hFF, 0, 0);
    strobe(8'hFF, 0, 0);
    expect_error("t3_ffff");
    strobe(8'hA5, 0, 0);
    check("t3_err_cleared_on_sync", err, 0);
    strobe(8'h01, 0, 0);
    strobe(8'h10, 0, 0);
    expect_error("t3_depth_plus1");
    pl = {};
    send_frame(pl, 8'h00);
    expect_loaded("t3_len0");

    // 4: inter-byte timeout after 3 of 8 payload bytes
    pulse_boot_req();
    strobe(8'hA5, 0, 0);
    strobe(8'h08, 0, 0);
    strobe(8'h00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      g = 8'($urandom);
      exp_q.push_back({BW'(i), g});
      strobe(g, 1, 0);
    end
    repeat (TIMEOUT - 1) @(negedge clk);
    check("t4_err_before_timeout", err, 0);
    @(negedge clk);
    expect_error("t4_timeout");
    repeat (20) @(negedge clk);
    check("t4_pending", exp_q.size(), 0);
    pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_frame(pl, 8'h00);
    expect_loaded("t4_recover");

    // 5: boot_req and an A5 strobe in the same RUN cycle
    @(negedge clk);
    boot_req = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    @(negedge clk);
    boot_req = 1'b0;
    rx_valid = 1'b0;
    check("t5_stall", core_stall, 1);
    check("t5_imem_addr_stalled", imem_addr, last_waddr);
    pl = {8'h77, 8'h88};
    send_frame(pl, 8'h00);
    expect_loaded("t5");

    // 6: reset mid-DATA, with a byte strobed in the reset cycle
    pulse_boot_req();
    strobe(8'hA5, 0, 0);
    strobe(8'h04, 0, 0);
    strobe(8'h00, 0, 0);
    for (int i = 0; i < 2; i++) begin
      g = 8'($urandom);
      exp_q.push_back({BW'(i), g});
      strobe(g, 1, 0);
    end
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    @(posedge clk);
    #1;
    check("t6_we", mem_we, 0);
    check("t6_stall", core_stall, 1);
    check("t6_err", err, 0);
    check("t6_waddr", mem_waddr, 0);
    check("t6_wdata", mem_wdata, 0);
    check("t6_done", load_done, 0);
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b0;
    pl = {8'hC0, 8'hFF, 8'hEE, 8'h01};
    send_frame(pl, 8'h00);
    expect_loaded("t6");

    // Random frames: random length, payload, checksum corruption and garbage bytes
    pulse_boot_req();
    for (int it = 0; it < 16; it++) begin
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        strobe(g, 0, rgap());
      end
      n   = $urandom_range(0, 20);
      bad = ($urandom_range(0, 3) == 0);
      pl  = {};
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      send_frame(pl, bad ? 8'($urandom_range(1, 255)) : 8'h00);
      if (bad) begin
        expect_error("rnd_bad");
      end else begin
        expect_loaded("rnd_good");
        repeat ($urandom_range(0, 3)) strobe(8'($urandom), 0, rgap());
        check("rnd_run_ignores_rx", core_stall, 0);
        pulse_boot_req();
      end
    end

    repeat (5) @(negedge clk);
    check("final_pending", exp_q.size(), 0);
    check("final_done", seen_done, exp_done);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
